// File: rtl/m_wbuf.sv
// m_wbuf: store write buffer that queues M-stage stores and drains them in order to data memory.
// Optional tail-entry store merging is enabled by defining M_WBUF_MERGE_EN.
module m_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_byteen,
    input  logic [31:0] st_wdata,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        stall,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic [4:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_last;

    logic st_req;
    logic full;
    logic deq;
    logic merge_hit;
    logic full_stall;
    logic ld_hit;
    logic enq;
    logic merge_wr;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_req    = st_valid && (st_byteen != 4'b0000);
    assign full      = (count == 5'(DEPTH));
    assign tail_last = tail - 1'b1;

    // Memory handshake: the head transfers on an edge where mem_valid && mem_ready;
    // while mem_valid && !mem_ready the head fields are held stable.
    assign deq = mem_valid && mem_ready;

`ifdef M_WBUF_MERGE_EN
    // A tail entry that is also the head being drained this edge cannot absorb a merge.
    assign merge_hit = st_req && (count != 5'd0) &&
                       (addr_q[tail_last] == st_addr[31:2]) &&
                       !(deq && (head == tail_last));
`else
    assign merge_hit = 1'b0;
`endif

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign full_stall = st_req && full && !merge_hit;
    assign stall      = full_stall || (ld_req && ld_hit);
    assign enq        = st_req && !stall && !merge_hit;
    assign merge_wr   = st_req && !stall && merge_hit;

    assign mem_valid  = (count != 5'd0);
    assign mem_addr   = mem_valid ? {addr_q[head], 2'b00} : 32'h0;
    assign mem_byteen = mem_valid ? be_q[head] : 4'h0;
    assign mem_wdata  = mem_valid ? data_q[head] : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= 5'd0;
            valid_q <= '0;
        end else begin
            if (deq) begin
                head          <= head + 1'b1;
                valid_q[head] <= 1'b0;
            end
            if (enq) begin
                tail          <= tail + 1'b1;
                valid_q[tail] <= 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: every read is qualified by count or valid_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= st_addr[31:2];
            be_q[tail]   <= st_byteen;
            data_q[tail] <= st_wdata;
        end else if (merge_wr) begin
            be_q[tail_last] <= be_q[tail_last] | st_byteen;
            for (int b = 0; b < 4; b++) begin
                if (st_byteen[b]) begin
                    data_q[tail_last][8*b +: 8] <= st_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_m_wbuf.sv
// Directed bench for m_wbuf (DEPTH 4); expectations for the merge case follow M_WBUF_MERGE_EN.
module tb_m_wbuf;
    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_byteen;
    logic [31:0] st_wdata;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        stall;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [4:0]  count;

    int checks;
    int failures;

    m_wbuf #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_byteen  (st_byteen),
        .st_wdata   (st_wdata),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .stall      (stall),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_byteen (mem_byteen),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        st_valid  = 1'b1;
        st_addr   = a;
        st_byteen = be;
        st_wdata  = d;
    endtask

    task automatic no_store();
        st_valid  = 1'b0;
        st_addr   = 32'h0;
        st_byteen = 4'h0;
        st_wdata  = 32'h0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        ld_req    = 1'b0;
        ld_addr   = 32'h0;
        mem_ready = 1'b0;
        no_store();
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single store, drained the cycle after it becomes visible
        mem_ready = 1'b1;
        store(32'h10, 4'b0011, 32'h0000ABCD);
        #1;
        chk("t1_no_bypass", 32'(mem_valid), 32'd0);
        chk("t1_stall", 32'(stall), 32'd0);
        tick();
        no_store();
        #1;
        chk("t1_valid", 32'(mem_valid), 32'd1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_be", 32'(mem_byteen), 32'h3);
        chk("t1_data", mem_wdata, 32'h0000ABCD);
        chk("t1_count", 32'(count), 32'd1);
        tick();
        chk("t1_count_after", 32'(count), 32'd0);
        chk("t1_valid_after", 32'(mem_valid), 32'd0);
        chk("t1_addr_zero", mem_addr, 32'h0);

        // Store with zero byte enables is not a request
        mem_ready = 1'b0;
        store(32'h50, 4'b0000, 32'hFFFF_FFFF);
        tick();
        no_store();
        #1;
        chk("be0_count", 32'(count), 32'd0);

        // Fill to DEPTH, full-stall on fifth store, then drain in order
        for (int i = 0; i < 4; i++) begin
            store(32'(4 * i), 4'hF, 32'h1000 + 32'(i));
            tick();
        end
        store(32'h20, 4'hF, 32'h2000);
        #1;
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_full_stall", 32'(stall), 32'd1);
        tick();
        chk("t2_count_held", 32'(count), 32'd4);
        chk("t2_head_stable", mem_addr, 32'h0);
        chk("t2_data_stable", mem_wdata, 32'h1000);
        mem_ready = 1'b1;
        #1;
        chk("t2_stall_drain_same_cycle", 32'(stall), 32'd1);
        tick();
        chk("t2_count_after_drain", 32'(count), 32'd3);
        chk("t2_head1", mem_addr, 32'h4);
        chk("t2_stall_clear", 32'(stall), 32'd0);
        tick();
        no_store();
        #1;
        chk("t2_count_enq_deq", 32'(count), 32'd3);
        chk("t2_head2", mem_addr, 32'h8);
        tick();
        chk("t2_head3", mem_addr, 32'hC);
        chk("t2_count2", 32'(count), 32'd2);
        tick();
        chk("t2_head4", mem_addr, 32'h20);
        chk("t2_head4_data", mem_wdata, 32'h2000);
        chk("t2_count1", 32'(count), 32'd1);
        tick();
        chk("t2_empty", 32'(count), 32'd0);
        chk("t2_empty_valid", 32'(mem_valid), 32'd0);
        mem_ready = 1'b0;

        // Load hazard against a queued store word
        store(32'h104, 4'hF, 32'h0000_0104);
        tick();
        no_store();
        ld_req  = 1'b1;
        ld_addr = 32'h106;
        #1;
        chk("t3_ld_stall", 32'(stall), 32'd1);
        tick();
        chk("t3_ld_stall_hold", 32'(stall), 32'd1);
        ld_addr = 32'h108;
        #1;
        chk("t3_ld_other_word", 32'(stall), 32'd0);
        ld_addr   = 32'h106;
        mem_ready = 1'b1;
        #1;
        chk("t3_ld_stall_again", 32'(stall), 32'd1);
        tick();
        chk("t3_drained_count", 32'(count), 32'd0);
        chk("t3_ld_stall_cleared", 32'(stall), 32'd0);
        ld_req    = 1'b0;
        ld_addr   = 32'h0;
        mem_ready = 1'b0;

        // Two byte stores to the same word
        store(32'h40, 4'b0001, 32'h0000_0011);
        tick();
        store(32'h41, 4'b0010, 32'h0000_2200);
        tick();
        no_store();
        #1;
        chk("t4_addr", mem_addr, 32'h40);
`ifdef M_WBUF_MERGE_EN
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_be", 32'(mem_byteen), 32'h3);
        chk("t4_data", mem_wdata, 32'h0000_2211);
        mem_ready = 1'b1;
        tick();
        chk("t4_drained", 32'(count), 32'd0);
`else
        chk("t4_count", 32'(count), 32'd2);
        chk("t4_be", 32'(mem_byteen), 32'h1);
        chk("t4_data", mem_wdata, 32'h0000_0011);
        mem_ready = 1'b1;
        tick();
        chk("t4_second_be", 32'(mem_byteen), 32'h2);
        chk("t4_second_data", mem_wdata, 32'h0000_2200);
        tick();
        chk("t4_drained", 32'(count), 32'd0);
`endif
        mem_ready = 1'b0;

        // Asynchronous reset while draining discards the queue
        store(32'h200, 4'hF, 32'hA);
        tick();
        store(32'h204, 4'hF, 32'hB);
        tick();
        store(32'h208, 4'hF, 32'hC);
        tick();
        no_store();
        #1;
        chk("t5_count3", 32'(count), 32'd3);
        mem_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(mem_valid), 32'd0);
        chk("t5_rst_count", 32'(count), 32'd0);
        chk("t5_rst_addr", mem_addr, 32'h0);
        chk("t5_rst_stall", 32'(stall), 32'd0);
        tick();
        chk("t5_rst_hold_count", 32'(count), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_transfer", 32'(mem_valid), 32'd0);
        end
        store(32'h300, 4'hF, 32'h0000_0300);
        tick();
        no_store();
        #1;
        chk("t5_new_valid", 32'(mem_valid), 32'd1);
        chk("t5_new_addr", mem_addr, 32'h300);
        tick();
        chk("t5_new_drained", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/m_wbuf.md
M_WBUF -- requirements
Module: m_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, store-queue entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port st_valid  input  1  M-stage store request.
REQ-005 SHALL have port st_addr  input  32  store byte address.
REQ-006 SHALL have port st_byteen  input  4  lane byte enables from byte-enable generator.
REQ-007 SHALL have port st_wdata  input  32  lane-aligned store data.
REQ-008 SHALL have port ld_req  input  1  M-stage load present.
REQ-009 SHALL have port ld_addr  input  32  load byte address.
REQ-010 SHALL have port stall  output  1  pipeline freeze request.
REQ-011 SHALL have port mem_valid  output  1  head entry offered to data memory.
REQ-012 SHALL have port mem_addr  output  32  word address, bits [1:0] always 0.
REQ-013 SHALL have port mem_byteen  output  4  head byte enables.
REQ-014 SHALL have port mem_wdata  output  32  head data.
REQ-015 SHALL have port mem_ready  input  1  memory accepts head this cycle.
REQ-016 SHALL have port count  output  5  occupied entries, 0..DEPTH.

Function
REQ-017 SHALL treat st_valid with st_byteen==0 as no request.
REQ-018 SHALL enqueue {st_addr[31:2],st_byteen,st_wdata} at the tail on a clock edge where a store request is present and stall is 0.
REQ-019 SHALL assert stall combinationally when a store request is present and count==DEPTH; a same-cycle drain does not clear full-stall.
REQ-020 SHALL assert stall combinationally when ld_req=1 and any occupied entry has word address equal to ld_addr[31:2].
REQ-021 SHALL drive mem_valid=1 whenever count!=0; mem_addr/mem_byteen/mem_wdata from the head entry, all zero when empty.
REQ-022 SHALL dequeue the head on an edge where mem_valid&&mem_ready; head fields SHALL hold stable while mem_valid&&!mem_ready.
REQ-023 SHALL keep count unchanged on simultaneous enqueue and dequeue; count+1 on enqueue only; count-1 on dequeue only.
REQ-024 SHALL present an accepted store on mem_valid no earlier than the cycle after acceptance (no combinational bypass).
REQ-025 SHALL wrap head and tail pointers modulo DEPTH.
REQ-026 SHALL drain entries in strict enqueue order.

Reset
REQ-027 SHALL on reset low immediately clear head, tail, count to 0; mem_valid=0, stall follows REQ-020 with empty queue (0), mem outputs 0.
REQ-028 SHALL discard all queued entries when reset asserts mid-drain; a held mem_ready has no effect during reset.

Configuration
REQ-029 SHALL with M_WBUF_MERGE_EN defined merge a store request into the tail entry when count>0, word addresses match, and that entry is not being dequeued this edge: bytes with st_byteen=1 overwritten, byteen ORed, count unchanged, no full-stall for that request.
REQ-030 SHALL without M_WBUF_MERGE_EN always allocate a new entry per REQ-018.

Verification
REQ-031 SHALL cover: reset, store addr 0x10 byteen 0011 data 0x0000ABCD, mem_ready=1 -> next cycle mem_valid=1 addr 0x10 byteen 0011 data 0x0000ABCD, following cycle count=0.
REQ-032 SHALL cover: mem_ready=0, five stores to 0x0,0x4,0x8,0xC,0x20 (DEPTH 4) -> count=4, stall=1 on fifth until first drain; then drain order 0x0,0x4,0x8,0xC,0x20.
REQ-033 SHALL cover: queued store to 0x104, load addr 0x106 -> stall=1 until that entry drains; load 0x108 -> stall=0.
REQ-034 SHALL cover: with merge, mem_ready=0, stores 0x40 byteen 0001 data 0x11, then 0x41 byteen 0010 data 0x2200 -> count=1, byteen 0011, data 0x00002211; without merge -> count=2.
REQ-035 SHALL cover: count=3 draining, reset low mid-cycle -> mem_valid=0, count=0 immediately, no mem transfers after release until new store.
